mac_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 8x8-signed, 32-bit-accumulate MAC unit between NUM_REQ requesters.
- Each requester submits a dot-product job (length + streamed operand pairs). The scheduler clears the MAC accumulator, issues each pair with a valid pulse, and waits for the MAC done.
- Returns the 32-bit result, with an ID and error flag, to the granted requester.
- Sits between the operand producers (systolic row feeders) and the MAC datapath.

---
 rtl/mac_rr_scheduler.sv | 160 ++++++++++++++++
 tb/tb_mac_rr_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rr_scheduler.sv
// Round-robin owner of one shared 8x8->32 MAC; result = 1 clear cycle + 4 cycles/pair, then RESP.
// Stalls in ISSUE while the owner's op_valid is low and in RESP until resp_ready; WAIT aborts after TIMEOUT cycles.
module mac_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    input  logic [NUM_REQ*8-1:0]       op_a,
    input  logic [NUM_REQ*8-1:0]       op_b,
    input  logic [NUM_REQ-1:0]         op_valid,
    output logic [NUM_REQ-1:0]         op_ready,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       mac_valid,
    output logic [7:0]                 mac_a,
    output logic [7:0]                 mac_b,
    output logic                       mac_clear,
    input  logic [31:0]                mac_y,
    input  logic                       mac_done,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [31:0]                resp_data,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       resp_err,
    output logic                       busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr, win, pick_idx;
    logic             pick_vld;
    logic [LEN_W-1:0] len_r, cnt;
    logic [TW-1:0]    tcnt;
    logic [7:0]       a_hold, b_hold, cur_a, cur_b;
    logic [31:0]      data_r;
    logic             err_r;
    logic             fire, last_done, tmo;

    assign cur_a     = op_a[int'(win)*8 +: 8];
    assign cur_b     = op_b[int'(win)*8 +: 8];
    assign fire      = (state == S_ISSUE) && op_valid[win];
    assign last_done = (state == S_WAIT) && mac_done && (cnt + LEN_W'(1) == len_r);
    // tcnt already counts the issue cycle, so TIMEOUT-1 here lands RESP TIMEOUT cycles after issue
    assign tmo       = (state == S_WAIT) && !mac_done && (tcnt == TW'(TIMEOUT - 1));

    // Cyclic search starting at ptr; descending loop lets the nearest requester win
    always_comb begin
        int j;
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = (len_r == '0) ? S_RESP : S_ISSUE;
            S_ISSUE: if (fire) state_nxt = S_WAIT;
            S_WAIT: begin
                if (mac_done)  state_nxt = (cnt + LEN_W'(1) == len_r) ? S_RESP : S_ISSUE;
                else if (tmo) state_nxt = S_RESP;
            end
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            win    <= '0;
            len_r  <= '0;
            cnt    <= '0;
            tcnt   <= '0;
            a_hold <= '0;
            b_hold <= '0;
            data_r <= '0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (pick_vld) begin
                    win   <= pick_idx;
                    len_r <= req_len[int'(pick_idx)*LEN_W +: LEN_W];
                    ptr   <= (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + IDW'(1);
                    cnt   <= '0;
                end
                S_CLEAR: begin
                    data_r <= '0;
                    err_r  <= 1'b0;
                end
                S_ISSUE: if (fire) begin
                    a_hold <= cur_a;
                    b_hold <= cur_b;
                    tcnt   <= TW'(1);
                end
                S_WAIT: begin
                    if (mac_done) begin
                        cnt <= cnt + LEN_W'(1);
                        if (last_done) begin
                            data_r <= mac_y;
                            err_r  <= 1'b0;
                        end
                    end else if (tmo) begin
                        data_r <= mac_y;
                        err_r  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Everything but mac_clear is forced low while reset is held
    always_comb begin
        op_ready   = '0;
        grant      = '0;
        mac_valid  = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_id    = '0;
        resp_err   = 1'b0;
        busy       = 1'b0;
        mac_clear  = reset || (state == S_CLEAR);
        if (!reset) begin
            busy = (state != S_IDLE);
            if (state != S_IDLE)  grant[win]    = 1'b1;
            if (state == S_ISSUE) op_ready[win] = 1'b1;
            mac_valid  = fire;
            mac_a      = (state == S_ISSUE) ? cur_a : a_hold;
            mac_b      = (state == S_ISSUE) ? cur_b : b_hold;
            resp_valid = (state == S_RESP);
            resp_data  = data_r;
            resp_id    = win;
            resp_err   = err_r;
        end
    end
endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Scoreboard bench for mac_rr_scheduler with a 3-cycle behavioural MAC.
module tb_mac_rr_scheduler;
    localparam int N  = 4;
    localparam int LW = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N*8-1:0]  op_a = '0;
    logic [N*8-1:0]  op_b = '0;
    logic [N-1:0]    op_valid = '0;
    logic [N-1:0]    op_ready, grant;
    logic            mac_valid, mac_clear, mac_done, resp_valid, resp_err, busy;
    logic            resp_ready = 1'b1;
    logic [7:0]      mac_a, mac_b;
    logic [31:0]     mac_y, resp_data;
    logic [1:0]      resp_id;

    always #5 clk = ~clk;

    mac_rr_scheduler #(.NUM_REQ(N), .LEN_W(LW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
        .grant(grant), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
        .mac_clear(mac_clear), .mac_y(mac_y), .mac_done(mac_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
    );

    // MAC model: done and updated accumulator appear 3 cycles after the issue cycle
    logic                done_en = 1'b1;
    logic [2:0]          vpipe = '0;
    logic signed [15:0]  p0 = '0;
    logic signed [15:0]  p1 = '0;
    logic [31:0]         acc = '0;
    always @(posedge clk) begin
        if (reset) vpipe <= '0;
        else       vpipe <= {vpipe[1:0], mac_valid};
        p0 <= $signed(mac_a) * $signed(mac_b);
        p1 <= p0;
        if (mac_clear)     acc <= '0;
        else if (vpipe[1]) acc <= acc + {{16{p1[15]}}, p1};
    end
    assign mac_done = vpipe[2] & done_en;
    assign mac_y    = acc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  id;
        logic        err;
    } rsp_t;

    rsp_t        exp_resp[$];
    int          exp_grant[$];
    int          valid_t[$];
    int          clear_t[$];
    int          resp_t[$];
    int          checks = 0;
    int          errors = 0;
    int          grants_seen = 0;
    logic [N-1:0] grant_q = '0;
    logic        rv_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    // Monitor: timestamps events and pops the scoreboard on grants and response handshakes
    always @(negedge clk) begin
        if (!reset) begin
            if (mac_valid) valid_t.push_back(cyc);
            if (mac_clear) clear_t.push_back(cyc);
            if (resp_valid && !rv_q) resp_t.push_back(cyc);
            if (grant != '0 && grant_q == '0) begin
                int g;
                grants_seen++;
                if (exp_grant.size() == 0) chk("unexpected_grant", 32'(grant), 0);
                else begin
                    g = exp_grant.pop_front();
                    chk("grant", 32'(grant), 32'(1) << g);
                end
            end
            if (resp_valid && resp_ready) begin
                rsp_t e;
                if (exp_resp.size() == 0) chk("unexpected_resp", 32'(resp_valid), 0);
                else begin
                    e = exp_resp.pop_front();
                    chk("resp_data", resp_data, e.d);
                    chk("resp_id", 32'(resp_id), 32'(e.id));
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
        end
        grant_q <= grant;
        rv_q    <= resp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[i*8 +: 8] = a;
        op_b[i*8 +: 8] = b;
    endtask

    task automatic clr_t();
        valid_t.delete();
        clear_t.delete();
        resp_t.delete();
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic [1:0] id, input logic err);
        rsp_t r;
        r.d = d; r.id = id; r.err = err;
        exp_resp.push_back(r);
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!busy && n < 50) begin @(negedge clk); n++; end
        chk(name, 32'(busy), 1);
    endtask

    task automatic accept_pair(input int i, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!op_ready[i] && n < 50) begin @(negedge clk); n++; end
        chk(name, 32'(op_ready[i]), 1);
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_resp.size() != 0) && n < 400) begin @(negedge clk); n++; end
        chk(name, 32'(exp_resp.size()) + 32'(busy), 0);
        tick();
    endtask

    task automatic start_job(input int i, input logic [LW-1:0] len, input string name);
        req_len[i*LW +: LW] = len;
        req[i] = 1'b1;
        wait_busy(name);
        tick();
        req[i] = 1'b0;
    endtask

    initial begin
        int base, n;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_mac_clear", 32'(mac_clear), 1);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_mac_clear", 32'(mac_clear), 0);
        chk("idle_op_ready", 32'(op_ready), 0);
        tick();

        // Fairness: all requesting, len 1, requester i multiplies (i+1)*2
        clr_t();
        for (int i = 0; i < N; i++) begin
            set_pair(i, 8'(i + 1), 8'd2);
            req_len[i*LW +: LW] = 6'd1;
        end
        exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
        exp_grant.push_back(3); exp_grant.push_back(0);
        push_rsp(32'd2, 2'd0, 1'b0); push_rsp(32'd4, 2'd1, 1'b0); push_rsp(32'd6, 2'd2, 1'b0);
        push_rsp(32'd8, 2'd3, 1'b0); push_rsp(32'd2, 2'd0, 1'b0);
        base = grants_seen;
        op_valid = '1;
        req = '1;
        n = 0;
        @(negedge clk);
        while (grants_seen < base + 5 && n < 300) begin @(negedge clk); n++; end
        chk("fair_grants", 32'(grants_seen - base), 5);
        tick();
        req = '0;
        wait_idle("fair_done");
        op_valid = '0;

        // Single job on requester 0: (2,3),(-4,5),(7,-1) -> -21
        clr_t();
        exp_grant.push_back(0);
        push_rsp(32'hFFFF_FFEB, 2'd0, 1'b0);
        set_pair(0, 8'd2, 8'd3);
        op_valid[0] = 1'b1;
        start_job(0, 6'd3, "single_busy");
        accept_pair(0, "single_p0");
        set_pair(0, 8'hFC, 8'd5);
        accept_pair(0, "single_p1");
        set_pair(0, 8'd7, 8'hFF);
        accept_pair(0, "single_p2");
        op_valid[0] = 1'b0;
        wait_idle("single_done");
        chk("single_nvalid", 32'(valid_t.size()), 3);
        chk("single_gap1", 32'(qat(valid_t, 1) - qat(valid_t, 0)), 4);
        chk("single_gap2", 32'(qat(valid_t, 2) - qat(valid_t, 1)), 4);
        chk("single_clear_to_issue", 32'(qat(valid_t, 0) - qat(clear_t, 0)), 1);
        chk("single_nclear", 32'(clear_t.size()), 1);
        chk("single_latency", 32'(qat(resp_t, 0) - qat(clear_t, 0)), 13);

        // Zero length on requester 2
        clr_t();
        exp_grant.push_back(2);
        push_rsp(32'd0, 2'd2, 1'b0);
        start_job(2, 6'd0, "zero_busy");
        wait_idle("zero_done");
        chk("zero_nvalid", 32'(valid_t.size()), 0);
        chk("zero_latency", 32'(qat(resp_t, 0) - qat(clear_t, 0)), 1);

        // Backpressure on requester 3: op_valid low 5 cycles, resp_ready low 3 cycles
        clr_t();
        exp_grant.push_back(3);
        push_rsp(32'd2, 2'd3, 1'b0);
        set_pair(3, 8'd1, 8'd1);
        op_valid[3] = 1'b1;
        resp_ready = 1'b0;
        start_job(3, 6'd2, "bp_busy");
        accept_pair(3, "bp_p0");
        op_valid[3] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!op_ready[3] && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_stall_ready", 32'(op_ready[3]), 1);
        end
        tick();
        op_valid[3] = 1'b1;
        accept_pair(3, "bp_p1");
        op_valid[3] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_resp_hold", 32'(resp_valid), 1);
            chk("bp_resp_data_hold", resp_data, 32'd2);
        end
        tick();
        resp_ready = 1'b1;
        wait_idle("bp_done");
        chk("bp_gap", 32'(qat(valid_t, 1) - qat(valid_t, 0)), 9);
        chk("bp_latency", 32'(qat(resp_t, 0) - qat(clear_t, 0)), 14);

        // Timeout on requester 1 with mac_done suppressed
        clr_t();
        done_en = 1'b0;
        exp_grant.push_back(1);
        push_rsp(32'd9, 2'd1, 1'b1);
        set_pair(1, 8'd3, 8'd3);
        op_valid[1] = 1'b1;
        start_job(1, 6'd1, "to_busy");
        accept_pair(1, "to_p0");
        op_valid[1] = 1'b0;
        wait_idle("to_done");
        chk("to_latency", 32'(qat(resp_t, 0) - qat(valid_t, 0)), 16);
        done_en = 1'b1;

        // Reset during WAIT abandons the job
        clr_t();
        exp_grant.push_back(2);
        set_pair(2, 8'd1, 8'd1);
        op_valid[2] = 1'b1;
        start_job(2, 6'd2, "rstjob_busy");
        accept_pair(2, "rstjob_p0");
        reset = 1'b1;
        op_valid[2] = 1'b0;
        @(negedge clk);
        chk("midrst_mac_clear", 32'(mac_clear), 1);
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_resp_valid", 32'(resp_valid), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_busy", 32'(busy), 0);
        chk("postrst_mac_clear", 32'(mac_clear), 0);
        tick();

        clr_t();
        exp_grant.push_back(3);
        push_rsp(32'hFFFF_FFF8, 2'd3, 1'b0);
        set_pair(3, 8'hFE, 8'd4);
        op_valid[3] = 1'b1;
        start_job(3, 6'd1, "postrst_job_busy");
        accept_pair(3, "postrst_p0");
        op_valid[3] = 1'b0;
        wait_idle("postrst_done");

        chk("leftover_resp", 32'(exp_resp.size()), 0);
        chk("leftover_grant", 32'(exp_grant.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
